// File: rtl/rc5_key_expand.sv
// RC5-32/12 key schedule: expands a 128-bit user key into the 26-word subkey table S.
// Define RC5_SKEY_FLAT_OUT_EN to also expose the whole table in parallel on skey_flat.
module rc5_key_expand (
  input  logic         clk,
  input  logic         clr,
  input  logic [127:0] key_in,
  input  logic         key_vld,
  output logic         busy,
  output logic         key_rdy,
  input  logic [4:0]   skey_addr,
  output logic [31:0]  skey_dout
`ifdef RC5_SKEY_FLAT_OUT_EN
  ,
  output logic [831:0] skey_flat
`endif
);

  localparam int          T        = 26;
  localparam int          C        = 4;
  localparam logic [31:0] P32      = 32'hB7E15163;
  localparam logic [31:0] Q32      = 32'h9E3779B9;
  localparam logic [4:0]  LAST_IDX = 5'd25;
  localparam logic [6:0]  LAST_IT  = 7'd77;

  typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_MIX, ST_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] s_q [T];
  logic [31:0] s_d [T];
  logic [31:0] l_q [C];
  logic [31:0] l_d [C];
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [4:0]  i_q, i_d;
  logic [1:0]  j_q, j_d;
  logic [6:0]  iter_q, iter_d;
  logic        busy_q, busy_d, rdy_q, rdy_d;

  logic [31:0] init_val, mix_a, mix_b;
  logic [4:0]  mix_rot;

  // A zero amount is special-cased so the right shift never reaches 32.
  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
    if (n == 5'd0) return x;
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

  assign init_val = P32 + Q32 * {27'd0, i_q};
  assign mix_a    = rotl(s_q[i_q] + a_q + b_q, 5'd3);
  assign mix_rot  = mix_a[4:0] + b_q[4:0];
  assign mix_b    = rotl(l_q[j_q] + mix_a + b_q, mix_rot);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    l_d     = l_q;
    a_d     = a_q;
    b_d     = b_q;
    i_d     = i_q;
    j_d     = j_q;
    iter_d  = iter_q;
    busy_d  = busy_q;
    rdy_d   = rdy_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (key_vld) begin
          for (int c = 0; c < C; c++) l_d[c] = key_in[32*c +: 32];
          a_d     = '0;
          b_d     = '0;
          i_d     = '0;
          j_d     = '0;
          iter_d  = '0;
          busy_d  = 1'b1;
          rdy_d   = 1'b0;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        s_d[i_q] = init_val;
        if (i_q == LAST_IDX) begin
          i_d     = '0;
          j_d     = '0;
          state_d = ST_MIX;
        end else begin
          i_d = i_q + 5'd1;
        end
      end
      ST_MIX: begin
        s_d[i_q] = mix_a;
        l_d[j_q] = mix_b;
        a_d      = mix_a;
        b_d      = mix_b;
        i_d      = (i_q == LAST_IDX) ? 5'd0 : i_q + 5'd1;
        j_d      = j_q + 2'd1;
        iter_d   = iter_q + 7'd1;
        if (iter_q == LAST_IT) begin
          busy_d  = 1'b0;
          rdy_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      for (int k = 0; k < T; k++) s_q[k] <= '0;
      for (int c = 0; c < C; c++) l_q[c] <= '0;
      a_q     <= '0;
      b_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      l_q     <= l_d;
      a_q     <= a_d;
      b_q     <= b_d;
      i_q     <= i_d;
      j_q     <= j_d;
      iter_q  <= iter_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
    end
  end

  assign busy    = busy_q;
  assign key_rdy = rdy_q;

  always_comb begin
    skey_dout = '0;
    if (skey_addr <= LAST_IDX) skey_dout = s_q[skey_addr];
  end

`ifdef RC5_SKEY_FLAT_OUT_EN
  always_comb begin
    skey_flat = '0;
    for (int k = 0; k < T; k++) skey_flat[32*k +: 32] = s_q[k];
  end
`endif

endmodule

// File: tb/tb_rc5_key_expand.sv
// Self-checking bench for rc5_key_expand: compares the subkey table against a
// plain software RC5 key schedule and checks timing, key_vld filtering and clr.
module tb_rc5_key_expand;

  logic         clk = 1'b0;
  logic         clr;
  logic [127:0] key_in;
  logic         key_vld;
  logic         busy;
  logic         key_rdy;
  logic [4:0]   skey_addr;
  logic [31:0]  skey_dout;
`ifdef RC5_SKEY_FLAT_OUT_EN
  logic [831:0] skey_flat;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  rc5_key_expand dut (
    .clk       (clk),
    .clr       (clr),
    .key_in    (key_in),
    .key_vld   (key_vld),
    .busy      (busy),
    .key_rdy   (key_rdy),
    .skey_addr (skey_addr),
    .skey_dout (skey_dout)
`ifdef RC5_SKEY_FLAT_OUT_EN
    ,
    .skey_flat (skey_flat)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [831:0] exp;
  } vec_t;

  vec_t vecs [4];

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Rotate by taking the upper half of a doubled word.
  function automatic logic [31:0] ref_rotl(input logic [31:0] x, input logic [31:0] n);
    logic [63:0] t;
    t = {x, x} << (n % 32);
    return t[63:32];
  endfunction

  task automatic model_schedule(input logic [127:0] k, output logic [831:0] flat);
    logic [31:0] s [26];
    logic [31:0] l [4];
    logic [31:0] a, b;
    int i, j;
    for (int c = 0; c < 4; c++) l[c] = k[32*c +: 32];
    for (int t = 0; t < 26; t++) s[t] = 32'hB7E15163 + 32'(t) * 32'h9E3779B9;
    a = 0; b = 0; i = 0; j = 0;
    for (int r = 0; r < 78; r++) begin
      a    = ref_rotl(s[i] + a + b, 3);
      s[i] = a;
      b    = ref_rotl(l[j] + a + b, a + b);
      l[j] = b;
      i    = (i + 1) % 26;
      j    = (j + 1) % 4;
    end
    flat = '0;
    for (int t = 0; t < 26; t++) flat[32*t +: 32] = s[t];
  endtask

  function automatic logic [63:0] model_encrypt(input logic [831:0] s);
    logic [31:0] a, b;
    a = s[31:0];
    b = s[63:32];
    for (int r = 1; r <= 12; r++) begin
      a = ref_rotl(a ^ b, b) + s[64*r +: 32];
      b = ref_rotl(b ^ a, a) + s[64*r + 32 +: 32];
    end
    return {a, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_s(input logic [4:0] addr, output logic [31:0] v);
    skey_addr = addr;
    #1;
    v = skey_dout;
  endtask

  task automatic read_table(output logic [831:0] flat);
    logic [31:0] v;
    flat = '0;
    for (int k = 0; k < 26; k++) begin
      read_s(5'(k), v);
      flat[32*k +: 32] = v;
    end
  endtask

  task automatic compare_table(input string name, input logic [831:0] exp);
    logic [831:0] got;
    logic [31:0]  v;
    read_table(got);
    for (int k = 0; k < 26; k++)
      check_output($sformatf("%s S[%0d]", name, k), 64'(got[32*k +: 32]), 64'(exp[32*k +: 32]));
    read_s(5'd31, v);
    check_output({name, " addr31"}, 64'(v), 64'd0);
`ifdef RC5_SKEY_FLAT_OUT_EN
    check_output({name, " flat lo"}, skey_flat[63:0], exp[63:0]);
    check_output({name, " flat hi"}, skey_flat[831:768], exp[831:768]);
`endif
  endtask

  task automatic apply_stimulus(input logic [127:0] k);
    key_in  = k;
    key_vld = 1'b1;
    tick();
    key_vld = 1'b0;
    check_output("rdy low after accept", 64'(key_rdy), 64'd0);
    check_output("busy high after accept", 64'(busy), 64'd1);
  endtask

  // Counts edges since the accepting edge until key_rdy rises, bounded.
  task automatic wait_ready(input string name, input int start);
    int lat;
    int busy_drop;
    lat = start;
    busy_drop = 0;
    while (key_rdy !== 1'b1 && lat < 300) begin
      if (busy !== 1'b1) busy_drop++;
      tick();
      lat++;
    end
    check_output({name, " latency"}, 64'(lat), 64'd104);
    check_output({name, " busy low at done"}, 64'(busy), 64'd0);
    check_output({name, " busy held"}, 64'(busy_drop), 64'd0);
  endtask

  initial begin
    logic [831:0] got, gold_a;
    logic [127:0] key_a, key_b;
    logic [31:0]  v, orv;
    int           drop;

    clr = 1'b1; key_vld = 1'b0; key_in = '0; skey_addr = '0;
    tick(); tick();
    clr = 1'b0;
    check_output("reset busy", 64'(busy), 64'd0);
    check_output("reset rdy", 64'(key_rdy), 64'd0);
    read_s(5'd0, v);  check_output("reset S[0]", 64'(v), 64'd0);
    read_s(5'd25, v); check_output("reset S[25]", 64'(v), 64'd0);

    vecs[0].key = '0;
    vecs[1].key = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    vecs[2].key = {$urandom, $urandom, $urandom, $urandom};
    vecs[3].key = {$urandom, $urandom, $urandom, $urandom};
    for (int n = 0; n < 4; n++) model_schedule(vecs[n].key, vecs[n].exp);

    // Zero key: peek at the freshly initialised table before mixing starts.
    apply_stimulus(vecs[0].key);
    repeat (26) tick();
    read_s(5'd0, v);  check_output("init S[0]", 64'(v), 64'hB7E15163);
    read_s(5'd1, v);  check_output("init S[1]", 64'(v), 64'h5618CB1C);
    read_s(5'd25, v); check_output("init S[25]", 64'(v), 64'h2B4C3474);
    wait_ready("zero key", 26);
    compare_table("zero key", vecs[0].exp);
    read_table(got);
    check_output("zero key ciphertext", model_encrypt(got), 64'hEEDBA521_6D8F4B15);

    for (int n = 1; n < 4; n++) begin
      apply_stimulus(vecs[n].key);
      wait_ready($sformatf("vec%0d", n), 0);
      compare_table($sformatf("vec%0d", n), vecs[n].exp);
    end

    // key_vld re-pulsed mid-expansion with a different key must be ignored.
    key_a = {$urandom, $urandom, $urandom, $urandom};
    key_b = ~key_a;
    model_schedule(key_a, gold_a);
    apply_stimulus(key_a);
    key_in = key_b;
    drop = 0;
    for (int c = 1; c <= 104; c++) begin
      key_vld = (c == 10 || c == 80);
      tick();
      if (c < 104 && busy !== 1'b1) drop++;
    end
    key_vld = 1'b0;
    check_output("repulse busy held", 64'(drop), 64'd0);
    check_output("repulse rdy", 64'(key_rdy), 64'd1);
    compare_table("repulse", gold_a);

    // clr in the middle of mixing discards the partial table.
    apply_stimulus(key_b);
    repeat (59) tick();
    clr = 1'b1;
    tick(); tick();
    clr = 1'b0;
    check_output("midclr busy", 64'(busy), 64'd0);
    check_output("midclr rdy", 64'(key_rdy), 64'd0);
    orv = '0;
    for (int k = 0; k < 26; k++) begin
      read_s(5'(k), v);
      orv |= v;
    end
    check_output("midclr table zero", 64'(orv), 64'd0);
    repeat (3) tick();
    check_output("midclr stays idle", 64'(busy), 64'd0);

    apply_stimulus(vecs[2].key);
    wait_ready("after clr", 0);
    compare_table("after clr", vecs[2].exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rc5_key_expand.md
Name: rc5_key_expand

Overview:
- RC5-32/12 key-schedule stage. It sits directly upstream of the RC5 encrypt/decrypt datapath.
- Takes a 128-bit user key and runs the standard RC5 expansion: magic-constant init, then 3*26 = 78 mixing iterations.
- Holds the resulting 26 x 32-bit subkey table S[0:25]. The round datapath reads S through an indexed read port, replacing the hard-coded skey table.

Parameters:
- T, 26, number of subkeys (2*rounds+2); fixed for RC5-32/12.
- C, 4, number of 32-bit user-key words (128-bit key).
- P32, 32'hB7E15163, RC5 magic constant P.
- Q32, 32'h9E3779B9, RC5 magic constant Q.

Ports:
- clk  in  1  system clock, all state on rising edge.
- clr  in  1  synchronous active-high reset.
- key_in  in  128  user key; L[j] = key_in[32j+31:32j], j=0..3.
- key_vld  in  1  request expansion of key_in; single-cycle pulse or level.
- busy  out  1  high while in ST_INIT or ST_MIX.
- key_rdy  out  1  high while the subkey table is valid (ST_DONE).
- skey_addr  in  5  subkey index for the read port.
- skey_dout  out  32  combinational S[skey_addr]; 0 when skey_addr > 25.

Behaviour:
- Reset (clr=1 at an edge):
  - state to ST_IDLE; busy=0, key_rdy=0.
  - S[0:25], L[0:3], A, B, i, j, and iteration counter all cleared to 0.
  - clr dominates every other input, including mid-expansion: any partial table is discarded.
- States: ST_IDLE, ST_INIT, ST_MIX, ST_DONE.
- ST_IDLE / ST_DONE:
  - If key_vld=1 at an edge: latch L[0:3] from key_in; A=B=0; i=0; iteration counter=0; key_rdy deasserts; go to ST_INIT.
  - Otherwise hold state.
- ST_INIT: one write per cycle, S[i] = P32 + i*Q32 (mod 2^32), i = 0..25.
  - On the edge that writes S[25]: i=0, j=0, go to ST_MIX.
- ST_MIX: exactly 78 iterations, one per cycle, all arithmetic mod 2^32.
  - A' = (S[i] + A + B) <<< 3; write S[i] = A'.
  - B' = (L[j] + A' + B) <<< (A' + B)[4:0]; write L[j] = B'.
  - A = A', B = B'.
  - i = (i==25) ? 0 : i+1; j = (j+1) mod 4 (2-bit wrap).
- Rotate rule: a rotate amount of 0 returns the operand unchanged. The implementation must not rely on a 32-bit shift yielding 0.
- After the 78th iteration: go to ST_DONE; key_rdy=1, busy=0.
- Latency: counting the accepting edge as edge 0, S writes occur on edges 1..26 and mix iterations on edges 27..104. key_rdy is high after edge 104, i.e. 104 cycles after accept.
- key_vld while busy=1: ignored. The latched key is not replaced and the in-progress expansion completes unchanged.
- key_vld in ST_DONE restarts expansion. key_rdy drops on the accepting edge; downstream must wait for key_rdy before starting a block.
- Read port:
  - Combinational in all states.
  - Values read while busy=1 are intermediate, not guaranteed.
  - Reads never modify state.

Optional Feature:
- Macro: RC5_SKEY_FLAT_OUT_EN.
- When defined: adds output skey_flat[831:0], with skey_flat[32k+31:32k] = S[k] and the same timing as skey_dout. This lets a fully unrolled round pipeline take all subkeys in parallel. The indexed read port remains.
- When undefined: the port is absent and only the indexed read port exists.

Test Plan:
- Reset: assert clr for 2 cycles mid-ST_MIX (edge 60) -> next cycle busy=0, key_rdy=0; skey_dout=0 for addr 0..25.
- Init check: hold the block in ST_MIX by sampling right after edge 26 (read S before mix writes) -> S[0]=B7E15163, S[1]=5618CB1C, S[25]=2B4C3474.
- Zero key, end-to-end: key_in=0, key_vld pulse -> key_rdy exactly 104 cycles later. Feed S into the round datapath with plaintext 0 -> ciphertext {A,B} = 64'hEEDBA521_6D8F4B15.
- Arbitrary key key_in=128'h0F0E0D0C_0B0A0908_07060504_03020100 -> all 26 skey_dout values match the software RC5 key-schedule golden model bit-exactly.
- key_vld re-pulsed at edges 10 and 80 with a different key -> final table equals the first key's golden table, and busy stays high throughout.
- Restart from ST_DONE with a new key -> key_rdy low on the accept edge, high again 104 cycles later, table matches the new key's golden model. skey_addr=31 -> skey_dout=0.
